// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - funsel encoding shared by reg_cell and reg_file_param
package reg_pkg;

    localparam int FUNSEL_W = 3;

    localparam logic [FUNSEL_W-1:0] FUNSEL_CLR  = 3'b000;
    localparam logic [FUNSEL_W-1:0] FUNSEL_LOAD = 3'b001;
    localparam logic [FUNSEL_W-1:0] FUNSEL_INC  = 3'b010;
    localparam logic [FUNSEL_W-1:0] FUNSEL_DEC  = 3'b011;
    localparam logic [FUNSEL_W-1:0] FUNSEL_SHL  = 3'b100;
    localparam logic [FUNSEL_W-1:0] FUNSEL_SHR  = 3'b101;
    localparam logic [FUNSEL_W-1:0] FUNSEL_ROL  = 3'b110;
    localparam logic [FUNSEL_W-1:0] FUNSEL_HOLD = 3'b111;

    typedef enum logic [FUNSEL_W-1:0] {
        FS_CLR  = FUNSEL_CLR,
        FS_LOAD = FUNSEL_LOAD,
        FS_INC  = FUNSEL_INC,
        FS_DEC  = FUNSEL_DEC,
        FS_SHL  = FUNSEL_SHL,
        FS_SHR  = FUNSEL_SHR,
        FS_ROL  = FUNSEL_ROL,
        FS_HOLD = FUNSEL_HOLD
    } funsel_e;

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - one register with clear/load/inc/dec/shift/rotate; REGFILE_SAT_EN selects saturating inc/dec
module reg_cell
    import reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [FUNSEL_W-1:0] funsel,
    input  logic [N-1:0]        load,
    output logic [N-1:0]        q,
    output logic                ovf
);

    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] next_q;
    logic         ovf_term;

    // Next value and overflow term for the selected operation on the current value
    always_comb begin
        next_q   = q;
        ovf_term = 1'b0;
        case (funsel_e'(funsel))
            FS_CLR:  next_q = '0;
            FS_LOAD: next_q = load;
            FS_INC: begin
                if (q == ALL_ONES) begin
                    ovf_term = 1'b1;
`ifdef REGFILE_SAT_EN
                    next_q   = ALL_ONES;
`else
                    next_q   = '0;
`endif
                end else begin
                    next_q = q + ONE;
                end
            end
            FS_DEC: begin
                if (q == '0) begin
                    ovf_term = 1'b1;
`ifdef REGFILE_SAT_EN
                    next_q   = '0;
`else
                    next_q   = ALL_ONES;
`endif
                end else begin
                    next_q = q - ONE;
                end
            end
            FS_SHL: begin
                next_q   = {q[N-2:0], 1'b0};
                ovf_term = q[N-1];
            end
            FS_SHR:  next_q = {1'b0, q[N-1:1]};
            FS_ROL:  next_q = {q[N-2:0], q[N-1]};
            FS_HOLD: next_q = q;
            default: next_q = q;
        endcase
    end

    // Only a selected cell may contribute to the overflow flag
    assign ovf = enable & ovf_term;

    // Register update: reset wins, otherwise apply operation when selected
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (enable) begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - R x N register file with per-register ops and two read ports; REGFILE_SAT_EN selects saturation
module reg_file_param
    import reg_pkg::*;
#(
    parameter int N  = 8,
    parameter int R  = 8,
    parameter int SW = $clog2(R)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        load,
    input  logic [FUNSEL_W-1:0] funsel,
    input  logic [R-1:0]        rsel,
    input  logic [SW-1:0]       o1sel,
    input  logic [SW-1:0]       o2sel,
    output logic [N-1:0]        o1,
    output logic [N-1:0]        o2,
    output logic                ovf
);

    localparam int RA = 2 ** SW;

    logic [N-1:0] q_arr  [R];
    logic [N-1:0] rd_arr [RA];
    logic [R-1:0] ovf_terms;

    for (genvar i = 0; i < R; i++) begin : g_cell
        reg_cell #(.N(N)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .enable (rsel[i]),
            .funsel (funsel),
            .load   (load),
            .q      (q_arr[i]),
            .ovf    (ovf_terms[i])
        );
    end

    // Pad the read view to a power of two so out-of-range addresses read as zero
    for (genvar i = 0; i < RA; i++) begin : g_rd
        if (i < R) begin : g_live
            assign rd_arr[i] = q_arr[i];
        end else begin : g_zero
            assign rd_arr[i] = '0;
        end
    end

    // Read ports reflect current register contents
    always_comb begin
        o1 = rd_arr[o1sel];
        o2 = rd_arr[o2sel];
    end

    // Overflow flag is valid for the single cycle after the offending edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= |ovf_terms;
        end
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter N, default 8, register width in bits (N >= 2).
REQ-002 SHALL have parameter R, default 8, number of registers (2..16); SW = $clog2(R).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  in  N  write data for load operations.
REQ-006 SHALL have port funsel  in  3  operation applied to every selected register.
REQ-007 SHALL have port rsel  in  R  one-hot-or-more register select; bit i selects register i.
REQ-008 SHALL have ports o1sel and o2sel  in  SW  read-port addresses.
REQ-009 SHALL have ports o1 and o2  out  N  read data.
REQ-010 SHALL have port ovf  out  1  registered wrap/saturation indicator.

Function
REQ-011 SHALL decode funsel: 000 clear, 001 load, 010 increment, 011 decrement, 100 shift-left logical, 101 shift-right logical, 110 rotate-left, 111 hold.
REQ-012 SHALL apply the operation on the rising clk edge to every register i with rsel[i]=1; unselected registers hold.
REQ-013 SHALL allow any number of rsel bits set simultaneously; all selected registers update independently from their own current value.
REQ-014 SHALL treat rsel=0 as a global hold, regardless of funsel.
REQ-015 SHALL drive o1/o2 combinationally from the current register contents (pre-edge value); write latency to read is one cycle.
REQ-016 SHALL drive o1/o2 to 0 when o1sel/o2sel >= R.
REQ-017 SHALL allow o1sel == o2sel; both ports return the same value.
REQ-018 SHALL, when REGFILE_SAT_EN is undefined, wrap modulo 2^N on increment (all-ones -> 0) and decrement (0 -> all-ones).
REQ-019 SHALL shift-left fill bit 0 with 0, shift-right fill bit N-1 with 0, and rotate-left move bit N-1 into bit 0.
REQ-020 SHALL assert ovf for exactly the cycle after an edge at which any selected register wrapped/saturated (increment at all-ones, decrement at 0) or shift-left discarded a 1; otherwise ovf is 0.
REQ-021 SHALL not assert ovf for clear, load, shift-right, rotate-left or hold.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, clear all R registers to 0 and ovf to 0, overriding funsel and rsel.
REQ-023 SHALL, with rst asserted mid-sequence (e.g. during a run of increments), discard the in-flight operation; the first post-reset edge operates on 0.
REQ-024 SHALL present o1=o2=0 in the cycle after reset.

Configuration
REQ-025 SHALL, with macro REGFILE_SAT_EN defined, saturate: increment at all-ones holds all-ones, decrement at 0 holds 0, and ovf asserts as in REQ-020.
REQ-026 SHALL, without REGFILE_SAT_EN, implement wrap-around per REQ-018; no other behaviour changes.

Structure
REQ-027 SHALL place the funsel encoding constants and the funsel enum typedef in shared package reg_pkg.
REQ-028 SHALL implement one register as sub-module reg_cell (parameter N; ports clk, rst, enable, funsel, load, q, ovf), instantiated R times with a generate loop.
REQ-029 SHALL form top-level ovf as the registered OR of reg_cell ovf terms from selected cells.

Verification (N=8, R=8)
REQ-030 SHALL cover: rst=1 one edge, then o1sel=0, o2sel=7 -> o1=0x00, o2=0x00, ovf=0.
REQ-031 SHALL cover: rsel=8'b0000_0101, funsel=001, load=0x95, one edge -> R0=R2=0x95, R1=0x00; then funsel=010 -> R0=R2=0x96.
REQ-032 SHALL cover: load R3=0xFF, increment -> R3=0x00 and ovf=1 for one cycle (wrap build) / R3=0xFF and ovf=1 (REGFILE_SAT_EN build); decrement from 0x00 mirrors to 0xFF/0x00.
REQ-033 SHALL cover: R1=0x95, shift-left -> 0x2A ovf=1; shift-right of 0x95 -> 0x4A ovf=0; rotate-left of 0x95 -> 0x2B ovf=0.
REQ-034 SHALL cover: rsel=0 with funsel=000 -> all registers unchanged; o1sel=o2sel=2 -> identical outputs.
REQ-035 SHALL cover: R=6 build, o1sel=6 -> o1=0x00; rst asserted during increment run of R5 (value 0x03) -> R5=0x00 next cycle.
